video_shifter: RTL and testbench

VIDEO_SHIFTER -- requirements
Module: video_shifter

---
 rtl/video_shifter.sv | 132 +++++++++++++
 tb/tb_video_shifter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_shifter.sv
// Character-mode video shifter: fetches a screen code and glyph row per 8-pixel character slot.
// Optional reverse video (code bit 7) is enabled by defining VIDEO_SHIFTER_INVERT_EN.
module video_shifter (
   input  logic        clk,
   input  logic        reset,
   output logic        cclk_en,
   input  logic        de,
   input  logic [9:0]  ma,
   input  logic [4:0]  ra,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        graphic,
   output logic        vram_req,
   output logic [9:0]  vram_addr,
   input  logic        vram_ack,
   input  logic [7:0]  vram_data,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        video,
   output logic        hsync,
   output logic        vsync,
   output logic        underrun,
   input  logic        underrun_clr
);

   typedef enum logic [0:0] {StIdle, StWait} fetch_e;

   fetch_e      fetch_q, fetch_d;
   logic [2:0]  p_q;
   logic        de_q, hs_q, vs_q;
   logic [4:0]  ra_q;
   logic [7:0]  code_q, code_d;
   logic [7:0]  glyph_q;
   logic [7:0]  shift_q;
   logic [7:0]  load_val;
   logic        ack_take, timeout, blank, inv;

   assign cclk_en = (p_q == 3'd7);
   assign video   = shift_q[7];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_q <= StIdle;
      end else begin
         fetch_q <= fetch_d;
      end
   end

   // Request window is phases 0..4; an unanswered request times out into a blank code.
   always_comb begin
      fetch_d  = fetch_q;
      ack_take = 1'b0;
      timeout  = 1'b0;
      vram_req = (fetch_q == StWait);
      case (fetch_q)
         StIdle: begin
            if (p_q == 3'd7 && de) fetch_d = StWait;
         end
         StWait: begin
            if (vram_ack) begin
               ack_take = 1'b1;
               fetch_d  = StIdle;
            end else if (p_q == 3'd4) begin
               timeout = 1'b1;
               fetch_d = StIdle;
            end
         end
         default: fetch_d = StIdle;
      endcase
   end

   always_comb begin
      code_d = code_q;
      if (ack_take) begin
         code_d = vram_data;
      end else if (timeout) begin
         code_d = 8'h20;
      end
   end

   assign blank = !de_q || (ra_q > 5'd7);

`ifdef VIDEO_SHIFTER_INVERT_EN
   assign inv = code_q[7];
`else
   assign inv = 1'b0;
`endif

   assign load_val = blank ? 8'h00 : (glyph_q ^ {8{inv}});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_q       <= 3'd0;
         de_q      <= 1'b0;
         ra_q      <= 5'd0;
         hs_q      <= 1'b0;
         vs_q      <= 1'b0;
         vram_addr <= 10'd0;
         code_q    <= 8'd0;
         rom_addr  <= 11'd0;
         glyph_q   <= 8'd0;
         shift_q   <= 8'd0;
         hsync     <= 1'b0;
         vsync     <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         p_q    <= p_q + 3'd1;
         code_q <= code_d;
         // Slot boundary: sample the CRTC and emit the previous slot's pixels and syncs.
         if (p_q == 3'd7) begin
            de_q    <= de;
            ra_q    <= ra;
            hs_q    <= hsync_in;
            vs_q    <= vsync_in;
            shift_q <= load_val;
            hsync   <= hs_q;
            vsync   <= vs_q;
            if (de) vram_addr <= ma;
         end else begin
            shift_q <= {shift_q[6:0], 1'b0};
         end
         if (p_q == 3'd4) rom_addr <= {graphic, code_d[6:0], ra_q[2:0]};
         if (p_q == 3'd6) glyph_q <= rom_data;
         if (timeout) begin
            underrun <= 1'b1;
         end else if (underrun_clr) begin
            underrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_video_shifter.sv
// Self-checking bench for video_shifter: directed vector table, corner sequences and
// randomized slots compared against a slot-level reference model with a 1-clk char ROM.
module tb_video_shifter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cclk_en;
   logic        de;
   logic [9:0]  ma;
   logic [4:0]  ra;
   logic        hsync_in, vsync_in, graphic;
   logic        vram_req;
   logic [9:0]  vram_addr;
   logic        vram_ack;
   logic [7:0]  vram_data;
   logic [10:0] rom_addr;
   logic [7:0]  rom_data;
   logic        video, hsync, vsync, underrun, underrun_clr;

   always #5 clk = ~clk;

   video_shifter dut (
      .clk          (clk),
      .reset        (reset),
      .cclk_en      (cclk_en),
      .de           (de),
      .ma           (ma),
      .ra           (ra),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .graphic      (graphic),
      .vram_req     (vram_req),
      .vram_addr    (vram_addr),
      .vram_ack     (vram_ack),
      .vram_data    (vram_data),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .video        (video),
      .hsync        (hsync),
      .vsync        (vsync),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   logic [7:0] rom_mem [2048];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

`ifdef VIDEO_SHIFTER_INVERT_EN
   localparam logic InvEn = 1'b1;
`else
   localparam logic InvEn = 1'b0;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_pix_prev;
   logic       exp_hs_prev, exp_vs_prev, und_model;

   typedef struct {
      logic       de;
      logic [9:0] ma;
      logic [4:0] ra;
      logic       hs;
      logic       vs;
      logic       gr;
      int         ack;
      logic [7:0] data;
      logic [7:0] romval;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [7:0] slot_code(input int ack, input logic [7:0] data);
      return (ack >= 0 && ack <= 4) ? data : 8'h20;
   endfunction

   // Pixels a slot should produce, straight from the display rules.
   function automatic logic [7:0] model_pix(input logic s_de, input logic [4:0] s_ra,
                                            input logic s_gr, input int ack,
                                            input logic [7:0] data);
      logic [7:0] code, g;
      if (!s_de || s_ra > 5'd7) return 8'h00;
      code = slot_code(ack, data);
      g = rom_mem[{s_gr, code[6:0], s_ra[2:0]}];
      if (InvEn && code[7]) g = ~g;
      return g;
   endfunction

   // Called at a negedge inside a p=7 cycle; leaves off at the next p=7 negedge.
   task automatic run_slot(input logic s_de, input logic [9:0] s_ma, input logic [4:0] s_ra,
                           input logic s_hs, input logic s_vs, input logic s_gr,
                           input int s_ack, input logic [7:0] s_data, input int s_clr,
                           input logic [7:0] s_exp, input logic spurious);
      logic [7:0] pix, hsv, vsv, reqv, ccv, exp_req, code;
      int ack_eff;
      ack_eff = (s_ack >= 0 && s_ack <= 4) ? s_ack : 4;
      code = slot_code(s_ack, s_data);
      de = s_de; ma = s_ma; ra = s_ra; hsync_in = s_hs; vsync_in = s_vs; graphic = s_gr;
      vram_ack = 1'b0; underrun_clr = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         pix[7-k]   = video;
         hsv[7-k]   = hsync;
         vsv[7-k]   = vsync;
         reqv[k]    = vram_req;
         ccv[k]     = cclk_en;
         exp_req[k] = s_de && (k <= ack_eff);
         chk("underrun", {31'd0, underrun}, {31'd0, und_model});
         if (k == 0 && s_de) chk("vram_addr", {22'd0, vram_addr}, {22'd0, s_ma});
         if (k == 5 && s_de)
            chk("rom_addr", {21'd0, rom_addr}, {21'd0, s_gr, code[6:0], s_ra[2:0]});
         vram_ack  = 1'b0;
         vram_data = 8'($urandom);
         if (s_de && k == s_ack) begin
            vram_ack  = 1'b1;
            vram_data = s_data;
         end else if (spurious && k < 7 && (!s_de || k > ack_eff)) begin
            vram_ack = 1'($urandom_range(0, 1));
         end
         underrun_clr = (k == s_clr);
         if (s_de && !(s_ack >= 0 && s_ack <= 4) && k == 4) und_model = 1'b1;
         else if (k == s_clr) und_model = 1'b0;
      end
      chk("video", {24'd0, pix}, {24'd0, exp_pix_prev});
      chk("hsync", {24'd0, hsv}, {24'd0, {8{exp_hs_prev}}});
      chk("vsync", {24'd0, vsv}, {24'd0, {8{exp_vs_prev}}});
      chk("vram_req", {24'd0, reqv}, {24'd0, exp_req});
      chk("cclk_en", {24'd0, ccv}, 32'h80);
      exp_pix_prev = s_exp;
      exp_hs_prev  = s_hs;
      exp_vs_prev  = s_vs;
   endtask

   task automatic count_to_cclk(input string name);
      int n;
      n = 0;
      while (!cclk_en && n < 20) begin
         @(negedge clk);
         n++;
         chk({name, "_req"}, {31'd0, vram_req}, 32'd0);
         vram_ack = 1'b0;
      end
      chk(name, n, 7);
   endtask

   initial begin
      logic [7:0] code, e;
      logic       r_de, r_hs, r_vs, r_gr;
      logic [4:0] r_ra;
      int         r_ack, r_clr;

      for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
      de = 1'b0; ma = '0; ra = '0; hsync_in = 1'b1; vsync_in = 1'b1; graphic = 1'b0;
      vram_ack = 1'b1; vram_data = 8'h41; underrun_clr = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cclk_en", {31'd0, cclk_en}, 32'd0);
      chk("rst_vram_req", {31'd0, vram_req}, 32'd0);
      chk("rst_video", {31'd0, video}, 32'd0);
      chk("rst_hsync", {31'd0, hsync}, 32'd0);
      chk("rst_vsync", {31'd0, vsync}, 32'd0);
      chk("rst_underrun", {31'd0, underrun}, 32'd0);
      chk("rst_vram_addr", {22'd0, vram_addr}, 32'd0);
      chk("rst_rom_addr", {21'd0, rom_addr}, 32'd0);
      reset = 1'b0;
      hsync_in = 1'b0; vsync_in = 1'b0;
      count_to_cclk("cclk_first");
      exp_pix_prev = 8'h00; exp_hs_prev = 1'b0; exp_vs_prev = 1'b0; und_model = 1'b0;

      vecs[0] = '{1'b1, 10'h123, 5'd2, 1'b0, 1'b0, 1'b0, 2, 8'h41, 8'h3C, 8'h3C};
      vecs[1] = '{1'b1, 10'h123, 5'd2, 1'b0, 1'b0, 1'b0, 2, 8'hC1, 8'h3C,
                  InvEn ? 8'hC3 : 8'h3C};
      vecs[2] = '{1'b1, 10'h3FF, 5'd7, 1'b0, 1'b1, 1'b1, -1, 8'hC5, 8'h81, 8'h81};
      vecs[3] = '{1'b0, 10'h055, 5'd0, 1'b1, 1'b0, 1'b0, -1, 8'h00, 8'h00, 8'h00};
      vecs[4] = '{1'b1, 10'h200, 5'd9, 1'b0, 1'b0, 1'b0, 0, 8'h55, 8'hFF, 8'h00};
      vecs[5] = '{1'b1, 10'h001, 5'd0, 1'b0, 1'b0, 1'b1, 4, 8'h7E, 8'hA5, 8'hA5};
      vecs[6] = '{1'b1, 10'h2AA, 5'd5, 1'b0, 1'b0, 1'b0, 0, 8'h91, 8'h0F,
                  InvEn ? 8'hF0 : 8'h0F};
      vecs[7] = '{1'b0, 10'h000, 5'd0, 1'b1, 1'b1, 1'b0, -1, 8'h00, 8'h00, 8'h00};

      for (int i = 0; i < 8; i++) begin
         code = slot_code(vecs[i].ack, vecs[i].data);
         if (vecs[i].de) rom_mem[{vecs[i].gr, code[6:0], vecs[i].ra[2:0]}] = vecs[i].romval;
         run_slot(vecs[i].de, vecs[i].ma, vecs[i].ra, vecs[i].hs, vecs[i].vs, vecs[i].gr,
                  vecs[i].ack, vecs[i].data, -1, vecs[i].exp, 1'b0);
      end

      // Clear the sticky flag, then clear on the same clk as a fresh timeout.
      run_slot(1'b0, 10'h0, 5'd0, 1'b0, 1'b0, 1'b0, -1, 8'h0, 2, 8'h00, 1'b0);
      e = model_pix(1'b1, 5'd3, 1'b0, -1, 8'h00);
      run_slot(1'b1, 10'h111, 5'd3, 1'b0, 1'b0, 1'b0, -1, 8'h00, 4, e, 1'b0);
      run_slot(1'b0, 10'h0, 5'd0, 1'b0, 1'b0, 1'b0, -1, 8'h0, -1, 8'h00, 1'b0);

      for (int n = 0; n < 80; n++) begin
         r_de  = ($urandom_range(0, 3) != 0);
         r_ra  = 5'($urandom_range(0, 9));
         r_hs  = 1'($urandom);
         r_vs  = 1'($urandom);
         r_gr  = 1'($urandom);
         r_ack = $urandom_range(0, 6);
         r_clr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
         code  = 8'($urandom);
         e     = model_pix(r_de, r_ra, r_gr, r_ack, code);
         run_slot(r_de, 10'($urandom), r_ra, r_hs, r_vs, r_gr, r_ack, code, r_clr, e, 1'b1);
      end
      run_slot(1'b0, 10'h0, 5'd0, 1'b0, 1'b0, 1'b0, -1, 8'h0, -1, 8'h00, 1'b0);

      // Reset in the middle of an outstanding fetch.
      de = 1'b1; ma = 10'h2AA; ra = 5'd1; hsync_in = 1'b1; vsync_in = 1'b1;
      vram_ack = 1'b0; underrun_clr = 1'b0;
      repeat (4) @(negedge clk);
      chk("r037_req_before", {31'd0, vram_req}, 32'd1);
      reset = 1'b1;
      #1;
      chk("r037_vram_req", {31'd0, vram_req}, 32'd0);
      chk("r037_video", {31'd0, video}, 32'd0);
      chk("r037_hsync", {31'd0, hsync}, 32'd0);
      chk("r037_vsync", {31'd0, vsync}, 32'd0);
      chk("r037_underrun", {31'd0, underrun}, 32'd0);
      chk("r037_cclk_en", {31'd0, cclk_en}, 32'd0);
      chk("r037_vram_addr", {22'd0, vram_addr}, 32'd0);
      chk("r037_rom_addr", {21'd0, rom_addr}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      vram_ack = 1'b1; vram_data = 8'h41;
      de = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      count_to_cclk("r037_cclk_first");
      exp_pix_prev = 8'h00; exp_hs_prev = 1'b0; exp_vs_prev = 1'b0; und_model = 1'b0;
      e = model_pix(1'b1, 5'd6, 1'b1, 1, 8'h5A);
      run_slot(1'b1, 10'h0F0, 5'd6, 1'b1, 1'b0, 1'b1, 1, 8'h5A, -1, e, 1'b1);
      run_slot(1'b0, 10'h0, 5'd0, 1'b0, 1'b0, 1'b0, -1, 8'h0, -1, 8'h00, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
